dac_sample_buffer: RTL and testbench
====================================

Name: dac_sample_buffer

Overview:
Stereo sample FIFO that sits directly upstream of dac_transmitter. It accepts left/right sample pairs from the synthesis/mixing pipeline over a valid/ready handshake and absorbs the burstiness of that pipeline. Once per I2S frame it presents one stable pair on left_data/right_data, which connect straight to dac_transmitter. The frame timing comes from the lrclk that dac_transmitter outputs, in the same clk domain.

Parameters:
WIDTH, 24, bits per channel sample; must match dac_transmitter WIDTH.
DEPTH_LOG2, 3, log2 of FIFO depth in stereo pairs (default 8 pairs).

Ports:
clk  input  1  system clock, rising edge.
nReset  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of FIFO contents and outputs.
in_left  input  WIDTH  left sample to enqueue.
in_right  input  WIDTH  right sample to enqueue.
in_valid  input  1  in_left/in_right are valid this cycle.
in_ready  output  1  FIFO can accept a pair this cycle.
lrclk  input  1  word clock from dac_transmitter.
left_data  output  WIDTH  left word to dac_transmitter.
right_data  output  WIDTH  right word to dac_transmitter.
fill_level  output  DEPTH_LOG2+1  number of stored pairs, 0..2^DEPTH_LOG2.
underrun  output  1  one-cycle pulse when a frame starts with the FIFO empty.
underrun_count  output  16  present only with DAC_UNDERRUN_COUNT_EN (see below).

Behaviour:
- Reset (async, nReset=0) and flush=1 both have the same effect: pointers=0, fill_level=0, left_data=right_data=0, underrun=0, lrclk history register=0. flush overrides push and pop in the same cycle.
- in_ready = (fill_level != 2^DEPTH_LOG2). This is combinational from registered state only, with no dependence on in_valid.
- Push: when in_valid && in_ready, the pair is written at wr_ptr on the clk edge and wr_ptr increments. Pointers are DEPTH_LOG2+1 bits, wrap naturally, and full/empty are derived from the MSB.
- Frame event: lrclk is registered once (lrclk_d). A frame event is lrclk_d==1 && lrclk==0, i.e. a falling edge detected one clk after lrclk falls. dac_transmitter latches both words when lrclk falls, so the outputs update one clk after that latch and then stay stable for the whole next frame.
- Pop on frame event, non-empty: left_data/right_data <= head pair on the same edge; rd_ptr increments.
- Frame event, empty: left_data/right_data <= 0 (mute); underrun=1 for exactly one clk; pointers unchanged.
- Outputs change only on frame events, reset, or flush. At all other times they hold.
- Simultaneous push and pop: both occur and fill_level is unchanged. When empty, a push in the same cycle as a frame event does not satisfy that pop; it counts as an underrun and the pushed pair becomes the head. When full, in_ready=0, so a frame event frees one slot and in_ready rises the next cycle.
- fill_level = wr_ptr - rd_ptr (modulo 2^(DEPTH_LOG2+1)), registered-state based.
- A rising edge of lrclk and a static lrclk never pop.
- The first frame event after reset with no data is an underrun.

Optional Feature:
DAC_UNDERRUN_COUNT_EN:
- Defined: the underrun_count port exists. It is a 16-bit counter that increments on every underrun pulse, saturates at 16'hFFFF, and is cleared by nReset and flush.
- Undefined: the port and counter are absent. underrun still pulses.

Test Plan:
1. Reset then push pairs (L=0x000001,R=0x100001)..(L=0x000003,R=0x100003), toggle lrclk with a 64-clk period -> fill_level 3; after 1st/2nd/3rd falling lrclk+1 clk, outputs show pairs 1/2/3 in order; 4th frame -> outputs 0, underrun one-clk pulse.
2. Push 9 pairs with in_valid held high and no lrclk edges -> in_ready low after the 8th accept, fill_level=8, 9th pair held off. One falling lrclk -> in_ready high next clk, 9th pair accepted, fill_level=8.
3. Frame event coinciding with a push when empty -> outputs 0, underrun=1, fill_level becomes 1; next frame outputs the pushed pair.
4. Hold lrclk high, then low for many cycles -> exactly one pop per falling edge; no pop on the rising edge.
5. Fill 5 pairs, then assert nReset=0 mid-frame asynchronously -> outputs 0, fill_level 0, in_ready 1 immediately. Same check with flush=1 for one clk, including a simultaneous push (push discarded).
6. With DAC_UNDERRUN_COUNT_EN: 3 empty frames -> underrun_count=3; flush -> 0. Without the macro: design compiles with no underrun_count port.

Source files
------------

// File: rtl/dac_sample_buffer.sv
// Stereo sample FIFO ahead of dac_transmitter. It pops one pair per falling lrclk edge and mutes (underrun) when empty.
// Defining DAC_UNDERRUN_COUNT_EN adds a saturating underrun_count output.
module dac_sample_buffer #(
    parameter int WIDTH      = 24,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic                flush,
    input  logic [WIDTH-1:0]    in_left,
    input  logic [WIDTH-1:0]    in_right,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                lrclk,
    output logic [WIDTH-1:0]    left_data,
    output logic [WIDTH-1:0]    right_data,
    output logic [DEPTH_LOG2:0] fill_level,
    output logic                underrun
`ifdef DAC_UNDERRUN_COUNT_EN
    ,
    output logic [15:0]         underrun_count
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = (DEPTH_LOG2 + 1)'(1);

    logic [WIDTH-1:0]    r_mem_l [DEPTH];
    logic [WIDTH-1:0]    r_mem_r [DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                r_lrclk_d;
    logic [WIDTH-1:0]    r_left;
    logic [WIDTH-1:0]    r_right;
    logic                r_underrun;

    logic w_empty;
    logic w_full;
    logic w_frame;
    logic w_push;
    logic w_pop;
    logic w_underrun_set;

    // Pointers carry one extra wrap bit: same index with differing MSB means full.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);

    assign w_frame        = r_lrclk_d && !lrclk;
    assign w_push         = in_valid && !w_full;
    assign w_pop          = w_frame && !w_empty;
    assign w_underrun_set = w_frame && w_empty;

    assign in_ready   = !w_full;
    assign fill_level = r_wr_ptr - r_rd_ptr;
    assign left_data  = r_left;
    assign right_data = r_right;
    assign underrun   = r_underrun;

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem_l[r_wr_ptr[DEPTH_LOG2-1:0]] <= in_left;
            r_mem_r[r_wr_ptr[DEPTH_LOG2-1:0]] <= in_right;
        end
    end

    // An empty-FIFO push coinciding with a frame event cannot be popped:
    // emptiness is judged from registered pointers, so the frame mutes instead.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_lrclk_d  <= 1'b0;
            r_left     <= '0;
            r_right    <= '0;
            r_underrun <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_lrclk_d  <= 1'b0;
            r_left     <= '0;
            r_right    <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_lrclk_d  <= lrclk;
            r_underrun <= w_underrun_set;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_left   <= r_mem_l[r_rd_ptr[DEPTH_LOG2-1:0]];
                r_right  <= r_mem_r[r_rd_ptr[DEPTH_LOG2-1:0]];
            end else if (w_frame) begin
                r_left  <= '0;
                r_right <= '0;
            end
        end
    end

`ifdef DAC_UNDERRUN_COUNT_EN
    logic [15:0] r_ur_cnt;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_ur_cnt <= '0;
        end else if (flush) begin
            r_ur_cnt <= '0;
        end else if (w_underrun_set && (r_ur_cnt != 16'hFFFF)) begin
            r_ur_cnt <= r_ur_cnt + 16'd1;
        end
    end

    assign underrun_count = r_ur_cnt;
`endif

endmodule

// File: tb/tb_dac_sample_buffer.sv
// Scoreboard bench for dac_sample_buffer: a queue-based reference FIFO predicts each frame's output pair.
module tb_dac_sample_buffer;
    localparam int WIDTH      = 24;
    localparam int DEPTH_LOG2 = 3;
    localparam int DEPTH      = 8;

    logic             clk      = 1'b0;
    logic             nReset   = 1'b0;
    logic             flush    = 1'b0;
    logic             in_valid = 1'b0;
    logic             lrclk    = 1'b0;
    logic [WIDTH-1:0] in_left  = '0;
    logic [WIDTH-1:0] in_right = '0;
    logic             in_ready;
    logic [WIDTH-1:0] left_data;
    logic [WIDTH-1:0] right_data;
    logic [DEPTH_LOG2:0] fill_level;
    logic             underrun;
`ifdef DAC_UNDERRUN_COUNT_EN
    logic [15:0]      underrun_count;
`endif

    always #5 clk = ~clk;

    dac_sample_buffer #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk        (clk),
        .nReset     (nReset),
        .flush      (flush),
        .in_left    (in_left),
        .in_right   (in_right),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .lrclk      (lrclk),
        .left_data  (left_data),
        .right_data (right_data),
        .fill_level (fill_level),
        .underrun   (underrun)
`ifdef DAC_UNDERRUN_COUNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    typedef struct { logic [WIDTH-1:0] l; logic [WIDTH-1:0] r; } pair_t;
    typedef struct { logic [WIDTH-1:0] l; logic [WIDTH-1:0] r; bit u; } exp_t;

    pair_t fifo_q[$];
    exp_t  exp_q[$];
    bit    prev_lr   = 1'b0;
    int    model_cnt = 0;
    logic [WIDTH-1:0] hold_l = '0;
    logic [WIDTH-1:0] hold_r = '0;

    int checks = 0;
    int errors = 0;

    bit auto_lr = 1'b0;
    int lr_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pairs, one pop or mute per observed lrclk falling edge.
    always @(negedge nReset) begin
        fifo_q.delete();
        exp_q.delete();
        prev_lr   = 1'b0;
        model_cnt = 0;
        hold_l    = '0;
        hold_r    = '0;
    end

    always @(posedge clk) begin : model
        bit    frame;
        bit    push;
        pair_t p;
        if (nReset) begin
            if (flush) begin
                fifo_q.delete();
                exp_q.push_back('{l: '0, r: '0, u: 1'b0});
                prev_lr   = 1'b0;
                model_cnt = 0;
            end else begin
                frame = prev_lr && !lrclk;
                push  = in_valid && (fifo_q.size() < DEPTH);
                if (frame) begin
                    if (fifo_q.size() > 0) begin
                        p = fifo_q.pop_front();
                        exp_q.push_back('{l: p.l, r: p.r, u: 1'b0});
                    end else begin
                        exp_q.push_back('{l: '0, r: '0, u: 1'b1});
                        if (model_cnt < 65535) model_cnt++;
                    end
                end
                if (push) fifo_q.push_back('{l: in_left, r: in_right});
                prev_lr = lrclk;
            end
        end
    end

    // Monitor: consumes one expected event per output update, otherwise outputs must hold.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (nReset) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                hold_l = e.l;
                hold_r = e.r;
                chk("underrun", 32'(underrun), 32'(e.u));
            end else begin
                chk("underrun_idle", 32'(underrun), 32'd0);
            end
            chk("left_data", 32'(left_data), 32'(hold_l));
            chk("right_data", 32'(right_data), 32'(hold_r));
            chk("fill_level", 32'(fill_level), 32'(fifo_q.size()));
            chk("in_ready", 32'(in_ready), 32'(fifo_q.size() < DEPTH));
`ifdef DAC_UNDERRUN_COUNT_EN
            chk("underrun_count", 32'(underrun_count), 32'(model_cnt));
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        if (auto_lr) begin
            lr_cnt++;
            if (lr_cnt == 32) begin
                lr_cnt = 0;
                lrclk  = ~lrclk;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_pair(input int i);
        in_left  = 24'(i);
        in_right = 24'(32'h100000 + i);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic start_auto();
        auto_lr = 1'b1;
        lr_cnt  = 0;
        lrclk   = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int  idx;
        bit  acc;
        #1;
        chk("rst_left", 32'(left_data), 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_underrun", 32'(underrun), 32'd0);
        #20;
        @(negedge clk);
        #2 nReset = 1'b1;

        // Three pairs, four frames: pairs 1..3 then a muted underrun frame.
        tick();
        start_auto();
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_pair(i);
            tick();
        end
        in_valid = 1'b0;
        ticks(4 * 64 + 4);

        // Fill to full with a ninth pair held off until a frame frees a slot.
        auto_lr = 1'b0;
        lrclk   = 1'b0;
        do_flush();
        idx      = 1;
        in_valid = 1'b1;
        for (int c = 0; c < 12 && idx <= 9; c++) begin
            set_pair(16 + idx);
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        chk("t2_held_off", 32'(idx), 32'd9);
        lrclk = 1'b1;
        for (int c = 0; c < 4; c++) begin
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        lrclk = 1'b0;
        for (int c = 0; c < 10 && idx <= 9; c++) begin
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        chk("t2_ninth_accepted", 32'(idx), 32'd10);
        in_valid = 1'b0;
        ticks(3);

        // Push coinciding with a frame on an empty FIFO.
        do_flush();
        lrclk = 1'b1;
        ticks(2);
        lrclk    = 1'b0;
        in_valid = 1'b1;
        set_pair(40);
        tick();
        in_valid = 1'b0;
        ticks(3);
        lrclk = 1'b1;
        ticks(5);
        lrclk = 1'b0;
        ticks(3);

        // Long static levels: only falling edges pop.
        for (int rep = 0; rep < 4; rep++) begin
            lrclk = 1'b1;
            for (int c = 0; c < 20; c++) begin
                in_valid = ($urandom_range(0, 3) == 0);
                set_pair(100 + 20 * rep + c);
                tick();
            end
            lrclk = 1'b0;
            for (int c = 0; c < 20; c++) begin
                in_valid = ($urandom_range(0, 3) == 0);
                set_pair(200 + 20 * rep + c);
                tick();
            end
        end
        in_valid = 1'b0;

        // Asynchronous reset mid-frame with five pairs stored.
        do_flush();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_pair(300 + i);
            tick();
        end
        in_valid = 1'b0;
        lrclk = 1'b1;
        tick();
        #3 nReset = 1'b0;
        #1;
        chk("arst_fill", 32'(fill_level), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        chk("arst_left", 32'(left_data), 32'd0);
        chk("arst_right", 32'(right_data), 32'd0);
        chk("arst_underrun", 32'(underrun), 32'd0);
        @(negedge clk);
        #2 nReset = 1'b1;
        lrclk = 1'b0;
        tick();

        // Flush with a simultaneous push discards the push.
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_pair(400 + i);
            tick();
        end
        set_pair(499);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_fill", 32'(fill_level), 32'd0);
        ticks(2);

        // Three empty frames then flush.
        start_auto();
        ticks(3 * 64 + 8);
`ifdef DAC_UNDERRUN_COUNT_EN
        chk("t6_count3", 32'(underrun_count), 32'd3);
        do_flush();
        chk("t6_count_flush", 32'(underrun_count), 32'd0);
`endif

        // Randomized traffic with varying burst rates and rare flushes.
        for (int seg = 0; seg < 6; seg++) begin
            int rate;
            rate = $urandom_range(1, 6);
            for (int c = 0; c < 500; c++) begin
                in_valid = ($urandom_range(0, 63) < rate);
                in_left  = 24'($urandom);
                in_right = 24'($urandom);
                flush    = ($urandom_range(0, 999) == 0);
                tick();
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        ticks(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
